// File: rtl/carry_save_resolver.sv
// carry_save_resolver: resolves a carry-save pair (C, S) into C+S, SEG_LEN bits per cycle, with a valid/ready handshake on each side
module carry_save_resolver #(
  parameter int BIT_LEN = 64,
  parameter int SEG_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_C,
  input  logic [BIT_LEN-1:0] in_S,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] out_sum,
  output logic               out_carry
);
  localparam int NUM_SEGS = (BIT_LEN + SEG_LEN - 1) / SEG_LEN;
  localparam int PAD = NUM_SEGS * SEG_LEN;
  localparam int TOP_W = BIT_LEN - (NUM_SEGS - 1) * SEG_LEN;
  localparam int IW = NUM_SEGS > 1 ? $clog2(NUM_SEGS) : 1;
  if (SEG_LEN < 1 || SEG_LEN > BIT_LEN) begin : g_bad_seg
    $error("SEG_LEN must be in 1..BIT_LEN");
  end
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [PAD-1:0] c_q, c_d, s_q, s_d, sum_q, sum_d;
  logic [IW-1:0] seg_q, seg_d;
  logic carry_q, carry_d, out_carry_q, out_carry_d;
  logic accept, add, last;
  logic [SEG_LEN:0] seg_sum;
  assign accept = state_q == IDLE && in_valid;
  assign add = state_q == ADD;
  assign last = seg_q == IW'(NUM_SEGS - 1);
  assign seg_sum = {1'b0, c_q[seg_q*SEG_LEN +: SEG_LEN]} + {1'b0, s_q[seg_q*SEG_LEN +: SEG_LEN]}
                 + {{SEG_LEN{1'b0}}, carry_q};
  always_comb begin
    state_d = accept ? ADD : (add && last) ? DONE : (state_q == DONE && out_ready) ? IDLE : state_q;
    c_d = accept ? PAD'(in_C) : c_q;
    s_d = accept ? PAD'(in_S) : s_q;
    seg_d = accept ? '0 : add ? seg_q + IW'(1) : seg_q;
    carry_d = accept ? 1'b0 : add ? seg_sum[SEG_LEN] : carry_q;
    out_carry_d = (add && last) ? seg_sum[TOP_W] : out_carry_q;
    sum_d = sum_q;
    if (add) sum_d[seg_q*SEG_LEN +: SEG_LEN] = seg_sum[SEG_LEN-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      s_q <= '0;
      sum_q <= '0;
      seg_q <= '0;
      carry_q <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      s_q <= s_d;
      sum_q <= sum_d;
      seg_q <= seg_d;
      carry_q <= carry_d;
      out_carry_q <= out_carry_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_sum = sum_q[BIT_LEN-1:0];
  assign out_carry = out_carry_q;
endmodule
